// File: rtl/pos_sweep_pkg.sv
// Shared types and sizing helpers for the product-of-sums sweep controller.
package pos_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DEF_SETTLE_CYCLES = 1;
   localparam int DEF_SETTLE_CW     = $clog2(DEF_SETTLE_CYCLES + 1);

   // Truth-table width for n variables.
   function automatic int tbl_w(input int n);
      return 1 << n;
   endfunction

   function automatic int settle_cw(input int settle_cycles);
      return $clog2(settle_cycles + 1);
   endfunction

endpackage

// File: rtl/pos_sweep_controller_settle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Latency: load takes effect on the next edge; no backpressure.
module settle_timer #(
   parameter int CW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          expired
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/pos_sweep_controller.sv
// Sweeps a combinational PoS function over all input combinations and checks it against a maxterm mask.
// Latency: one index per SETTLE_CYCLES+1 cycles, done one cycle after the last sample; no backpressure.
module pos_sweep_controller
   import pos_sweep_pkg::*;
#(
   parameter int N_VARS        = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [tbl_w(N_VARS)-1:0]    maxterm_mask,
   input  logic                        func_out,
   output logic [N_VARS-1:0]           vars_out,
   output logic                        busy,
   output logic                        sample_valid,
   output logic [N_VARS-1:0]           sample_idx,
   output logic                        done,
   output logic                        aborted,
   output logic                        pass,
   output logic [N_VARS:0]             mismatch_count,
   output logic                        first_fail_valid,
   output logic [N_VARS-1:0]           first_fail_idx,
   output logic [tbl_w(N_VARS)-1:0]    captured_table
);

   localparam int TW = tbl_w(N_VARS);
   localparam int CW = settle_cw(SETTLE_CYCLES);
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

   state_t            state, state_nxt;
   logic [TW-1:0]     mask_q;
   logic [N_VARS-1:0] idx;
   logic              tmr_load;
   logic              tmr_expired;
   logic              last;
   logic              mism;
   logic [N_VARS:0]   count_nxt;

   settle_timer #(.CW(CW)) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (RELOAD),
      .expired  (tmr_expired)
   );

   // A maxterm bit of 1 means the function must evaluate to 0 there.
   assign last      = (idx == {N_VARS{1'b1}});
   assign mism      = (func_out != ~mask_q[idx]);
   assign count_nxt = mismatch_count + {{N_VARS{1'b0}}, mism};
   assign vars_out  = idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SETTLE;
               tmr_load  = 1'b1;
            end
         end
         SETTLE: begin
            if (abort)            state_nxt = IDLE;
            else if (tmr_expired) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (last) begin
               state_nxt = DONE;
            end else begin
               state_nxt = SETTLE;
               tmr_load  = 1'b1;
            end
         end
         DONE: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q           <= '0;
         idx              <= '0;
         busy             <= 1'b0;
         sample_valid     <= 1'b0;
         sample_idx       <= '0;
         done             <= 1'b0;
         aborted          <= 1'b0;
         pass             <= 1'b0;
         mismatch_count   <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
         captured_table   <= '0;
      end else begin
         sample_valid <= 1'b0;
         done         <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               mask_q           <= maxterm_mask;
               idx              <= '0;
               busy             <= 1'b1;
               aborted          <= 1'b0;
               pass             <= 1'b0;
               mismatch_count   <= '0;
               first_fail_valid <= 1'b0;
               first_fail_idx   <= '0;
               captured_table   <= '0;
            end
         end else if (abort) begin
            // Partial results stay visible for post-mortem.
            busy    <= 1'b0;
            aborted <= 1'b1;
            pass    <= 1'b0;
         end else if (state == DONE) begin
            busy <= 1'b0;
         end else if (state == SAMPLE) begin
            captured_table[idx] <= func_out;
            sample_valid        <= 1'b1;
            sample_idx          <= idx;
            mismatch_count      <= count_nxt;
            if (mism && !first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_idx   <= idx;
            end
            if (last) begin
               done <= 1'b1;
               pass <= (count_nxt == '0);
            end else begin
               idx <= idx + N_VARS'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pos_sweep_controller.sv
// Directed bench: N=4/S=1 and N=3/S=3 instances, checking results, timing, abort and reset.
module tb_pos_sweep_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Instance A: N_VARS=4, SETTLE_CYCLES=1
   logic        start_a = 1'b0, abort_a = 1'b0, func_a;
   logic [15:0] mask_a = '0;
   logic [3:0]  vars_a, sidx_a, ffi_a;
   logic        busy_a, sv_a, done_a, abt_a, pass_a, ffv_a;
   logic [4:0]  mc_a;
   logic [15:0] cap_a;
   int          mode_a = 0;

   // Instance B: N_VARS=3, SETTLE_CYCLES=3
   logic        start_b = 1'b0, abort_b = 1'b0, func_b;
   logic [7:0]  mask_b = '0;
   logic [2:0]  vars_b, sidx_b, ffi_b;
   logic        busy_b, sv_b, done_b, abt_b, pass_b, ffv_b;
   logic [3:0]  mc_b;
   logic [7:0]  cap_b;

   pos_sweep_controller #(.N_VARS(4), .SETTLE_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .maxterm_mask(mask_a), .func_out(func_a), .vars_out(vars_a),
      .busy(busy_a), .sample_valid(sv_a), .sample_idx(sidx_a), .done(done_a),
      .aborted(abt_a), .pass(pass_a), .mismatch_count(mc_a),
      .first_fail_valid(ffv_a), .first_fail_idx(ffi_a), .captured_table(cap_a)
   );

   pos_sweep_controller #(.N_VARS(3), .SETTLE_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .maxterm_mask(mask_b), .func_out(func_b), .vars_out(vars_b),
      .busy(busy_b), .sample_valid(sv_b), .sample_idx(sidx_b), .done(done_b),
      .aborted(abt_b), .pass(pass_b), .mismatch_count(mc_b),
      .first_fail_valid(ffv_b), .first_fail_idx(ffi_b), .captured_table(cap_b)
   );

   // Function under test: correct PoS, stuck-at-1 at index 11, or tied low.
   always_comb begin
      case (mode_a)
         0:       func_a = ~mask_a[vars_a];
         1:       func_a = (vars_a == 4'd11) ? 1'b1 : ~mask_a[vars_a];
         default: func_a = 1'b0;
      endcase
   end
   assign func_b = ~mask_b[vars_b];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulses start, then returns in the cycle done is seen (cycle 1 = first after start).
   task automatic run_a(output int done_cyc);
      int cyc;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      done_cyc = -1;
      for (cyc = 1; cyc < 200; cyc++) begin
         if (done_a) begin
            done_cyc = cyc;
            break;
         end
         tick();
      end
   endtask

   initial begin
      int dc;
      int nsv;
      int ndone;
      int cyc;

      // Reset state
      #1;
      chk("rst_vars", vars_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_pass", pass_a, 0);
      chk("rst_mc", mc_a, 0);
      chk("rst_cap", cap_a, 0);
      chk("rst_ffv", ffv_a, 0);
      chk("rst_sv", sv_a, 0);
      #10 rst_n = 1'b1;
      tick();

      // Correct PoS, N=4, S=1
      mask_a = 16'h28E7;
      mode_a = 0;
      run_a(dc);
      chk("t1_done_cyc", dc, 33);
      chk("t1_pass", pass_a, 1);
      chk("t1_mc", mc_a, 0);
      chk("t1_ffv", ffv_a, 0);
      chk("t1_cap", cap_a, 16'hD718);
      chk("t1_busy_in_done", busy_a, 1);
      tick();
      chk("t1_busy_after", busy_a, 0);
      chk("t1_done_pulse", done_a, 0);
      chk("t1_cap_hold", cap_a, 16'hD718);
      chk("t1_pass_hold", pass_a, 1);

      // Abort in IDLE is ignored
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      chk("idle_abort_abt", abt_a, 0);
      chk("idle_abort_busy", busy_a, 0);
      chk("idle_abort_cap", cap_a, 16'hD718);

      // Stuck-at-1 at index 11
      mode_a = 1;
      run_a(dc);
      chk("t2_done_cyc", dc, 33);
      chk("t2_pass", pass_a, 0);
      chk("t2_mc", mc_a, 1);
      chk("t2_ffv", ffv_a, 1);
      chk("t2_ffi", ffi_a, 11);
      chk("t2_cap", cap_a, 16'hDF18);
      tick();

      // Output tied low
      mode_a = 2;
      run_a(dc);
      chk("t3_mc", mc_a, 8);
      chk("t3_ffi", ffi_a, 3);
      chk("t3_pass", pass_a, 0);
      chk("t3_cap", cap_a, 0);
      tick();

      // N=3, S=3: hold time, sample pulses and done timing
      mask_b = 8'hCA;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      nsv = 0;
      dc = -1;
      for (cyc = 1; cyc < 100; cyc++) begin
         if (cyc <= 32) chk("b_vars", vars_b, (cyc - 1) / 4);
         if (sv_b) begin
            chk("b_sidx", sidx_b, nsv);
            chk("b_sv_cyc", cyc, 4 * nsv + 5);
            nsv++;
         end
         if (done_b) begin
            dc = cyc;
            break;
         end
         tick();
      end
      chk("b_nsv", nsv, 8);
      chk("b_done_cyc", dc, 33);
      chk("b_pass", pass_b, 1);
      chk("b_mc", mc_b, 0);
      chk("b_cap", cap_b, 8'h35);
      tick();
      chk("b_busy_after", busy_b, 0);

      // Start re-asserted while busy, then abort
      mode_a = 0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (cyc = 1; cyc < 10; cyc++) tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("ab_no_restart_vars", vars_a, 5);
      chk("ab_busy", busy_a, 1);
      for (cyc = 11; cyc < 15; cyc++) tick();
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      chk("ab_busy_low", busy_a, 0);
      chk("ab_aborted", abt_a, 1);
      chk("ab_pass", pass_a, 0);
      chk("ab_cap_partial", cap_a, 16'h0018);
      chk("ab_mc", mc_a, 0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_a) ndone++;
         tick();
      end
      chk("ab_no_done", ndone, 0);
      chk("ab_sticky", abt_a, 1);

      // Start and abort together in IDLE: start wins and clears aborted
      mode_a = 1;
      start_a = 1'b1;
      abort_a = 1'b1;
      tick();
      start_a = 1'b0;
      abort_a = 1'b0;
      chk("sa_busy", busy_a, 1);
      chk("sa_aborted", abt_a, 0);

      // Asynchronous reset in cycle 20
      for (cyc = 1; cyc < 20; cyc++) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mr_busy", busy_a, 0);
      chk("mr_vars", vars_a, 0);
      chk("mr_cap", cap_a, 0);
      chk("mr_mc", mc_a, 0);
      chk("mr_ffv", ffv_a, 0);
      chk("mr_ffi", ffi_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("mr_idle_done", done_a, 0);

      // Clean sweep after reset
      run_a(dc);
      chk("pr_done_cyc", dc, 33);
      chk("pr_mc", mc_a, 1);
      chk("pr_ffi", ffi_a, 11);
      chk("pr_cap", cap_a, 16'hDF18);
      chk("pr_pass", pass_a, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
